// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared constants and types for the UART instruction loader
//
// Purpose: terminator word, FSM state type and byte-count width used by the
//          loader top and its word assembler.
// Ports:   none (package).
package uart_loader_pkg;

  localparam logic [31:0] LOADER_TERM = 32'hFFFF_FFFF;
  localparam int          BCNT_W      = 2;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } loader_state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - packs UART bytes LSB-first into 32-bit words
//
// Purpose: holds bytes 0-2 of the word in progress, discards a partial word
//          on BREAK or after TIMEOUT_CYC idle cycles, and flags the cycle in
//          which byte 3 completes a word.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   en          assembler active (loader still in LOAD)
//   rx_valid    byte strobe, rx_data holds the byte
//   rx_data     received byte
//   rx_break    BREAK seen; drops partial word and coincident byte
//   word_valid  combinational: a complete word is presented this cycle
//   word        combinational: {rx_data, shreg}
module loader_word_assembler
  import uart_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_break,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int IDLE_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [23:0]       shreg;
  logic [BCNT_W-1:0] bcnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout;

  // Timeout only matters while a partial word is held.
  assign timeout = (bcnt != '0) && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  // A byte landing on the timeout cycle starts a new word, so it never completes one.
  assign word_valid = en && rx_valid && !rx_break && !timeout && (bcnt == 2'd3);
  assign word       = {rx_data, shreg};

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      bcnt     <= '0;
      idle_cnt <= '0;
    end else if (en) begin
      if (rx_break) begin
        bcnt     <= '0;
        idle_cnt <= '0;
      end else if (rx_valid) begin
        idle_cnt <= '0;
        if (timeout) begin
          shreg[7:0] <= rx_data;
          bcnt       <= 2'd1;
        end else begin
          case (bcnt)
            2'd0:    shreg[7:0]   <= rx_data;
            2'd1:    shreg[15:8]  <= rx_data;
            2'd2:    shreg[23:16] <= rx_data;
            default: ;
          endcase
          bcnt <= bcnt + 2'd1;  // wraps 3 -> 0 when the word completes
        end
      end else if (timeout) begin
        bcnt     <= '0;
        idle_cnt <= '0;
      end else if (bcnt != '0) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_instr_loader.sv
// rtl/uart_instr_loader.sv - writes UART-received instruction words into imem
//
// Purpose: assembles bytes into words, writes them to sequential word
//          addresses from 0, stops on 32'hFFFF_FFFF or when memory is full,
//          and holds the core in reset until loading is done.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rx_valid     byte strobe from the UART receiver
//   rx_data      received byte
//   rx_break     UART BREAK (level or pulse)
//   imem_we      one-cycle instruction-memory write strobe
//   imem_addr    word address of the write
//   imem_wdata   instruction word written
//   write_done   sticky, loading finished
//   overflow     sticky, a word arrived with memory already full
//   core_hold    ~write_done
module uart_instr_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              write_done,
  output logic              overflow,
  output logic              core_hold
);

  loader_state_t state;
  logic [ADDR_W:0] waddr;  // MSB set means memory is full
  logic            word_valid;
  logic [31:0]     word;

  loader_word_assembler #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .en         (state == LOAD),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_break   (rx_break),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      waddr      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      write_done <= 1'b0;
      overflow   <= 1'b0;
      core_hold  <= 1'b1;
    end else begin
      imem_we <= 1'b0;
      case (state)
        LOAD: begin
          if (word_valid) begin
            if (word == LOADER_TERM) begin
              write_done <= 1'b1;
              core_hold  <= 1'b0;
              state      <= DONE;
            end else if (!waddr[ADDR_W]) begin
              imem_we    <= 1'b1;
              imem_addr  <= waddr[ADDR_W-1:0];
              imem_wdata <= word;
              waddr      <= waddr + (ADDR_W+1)'(1);
            end else begin
              overflow   <= 1'b1;
              write_done <= 1'b1;
              core_hold  <= 1'b0;
              state      <= DONE;
            end
          end
        end
        default: ;  // DONE: only rst leaves
      endcase
    end
  end

endmodule

// File: tb/tb_uart_instr_loader.sv
// tb/tb_uart_instr_loader.sv - self-checking bench for uart_instr_loader
module tb_uart_instr_loader;

  localparam int AW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_break = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          write_done;
  logic          overflow;
  logic          core_hold;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]  pend[$];
  int          m_idle;
  bit          m_done, m_ovf, m_we;
  int          m_nwr;
  logic [31:0] m_addr, m_wdata;

  always #5 clk = ~clk;

  uart_instr_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_break   (rx_break),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .write_done (write_done),
    .overflow   (overflow),
    .core_hold  (core_hold)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_word(input logic [31:0] w);
    if (w == 32'hFFFF_FFFF) m_done = 1;
    else if (m_nwr < (1 << AW)) begin
      m_we = 1; m_addr = m_nwr; m_wdata = w; m_nwr++;
    end else begin
      m_ovf = 1; m_done = 1;
    end
  endtask

  task automatic model_cycle(input bit v, input logic [7:0] d, input bit b, input bit r);
    m_we = 0;
    if (r) begin
      pend.delete(); m_idle = 0; m_done = 0; m_ovf = 0; m_nwr = 0;
      m_addr = 0; m_wdata = 0;
    end else if (!m_done) begin
      if (b) begin
        pend.delete(); m_idle = 0;
      end else begin
        if (pend.size() > 0 && m_idle == TO - 1) begin
          pend.delete(); m_idle = 0;
        end
        if (v) begin
          pend.push_back(d); m_idle = 0;
          if (pend.size() == 4) begin
            model_word({pend[3], pend[2], pend[1], pend[0]});
            pend.delete();
          end
        end else if (pend.size() > 0) m_idle++;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit b, input bit r);
    @(negedge clk);
    rx_valid = v; rx_data = d; rx_break = b; rst = r;
    model_cycle(v, d, b, r);
    @(posedge clk);
    #1;
    check("imem_we", {31'd0, imem_we}, {31'd0, m_we});
    if (m_we) begin
      check("imem_addr", {{(32-AW){1'b0}}, imem_addr}, m_addr);
      check("imem_wdata", imem_wdata, m_wdata);
    end
    check("write_done", {31'd0, write_done}, {31'd0, m_done});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("core_hold", {31'd0, core_hold}, {31'd0, !m_done});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    idle(gap);
    step(1, d, 0, 0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], $urandom_range(0, 2));
  endtask

  task automatic do_reset;
    step(0, 8'h00, 0, 1);
    check("rst_addr", {{(32-AW){1'b0}}, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] w;

    do_reset();

    // happy path
    send_word(32'hF9010113);
    check("hp_w0", imem_wdata, 32'hF9010113);
    send_word(32'h06812623);
    check("hp_w1", imem_wdata, 32'h06812623);
    check("hp_a1", {{(32-AW){1'b0}}, imem_addr}, 32'd1);
    send_word(32'hFFFF_FFFF);
    check("hp_done", {31'd0, write_done}, 32'd1);
    send_word(32'h12345678);  // ignored in DONE
    step(1, 8'h55, 1, 0);
    idle(3);

    // break mid-word, plus a break coincident with a byte
    do_reset();
    send(8'h13, 0); send(8'h01, 0);
    step(0, 8'h00, 1, 0);
    send(8'hAA, 0); send(8'hBB, 1); send(8'hCC, 0); send(8'hDD, 0);
    check("brk_w", imem_wdata, 32'hDDCCBBAA);
    send(8'h01, 0); step(1, 8'h77, 1, 0);
    send_word(32'h0BAD_F00D);

    // timeout: discarded after 20 idle cycles, kept after 10, edge cases at 14/15
    do_reset();
    send(8'h11, 0);
    send(8'h44, 20); send(8'h33, 0); send(8'h22, 0); send(8'h11, 0);
    check("to_w", imem_wdata, 32'h11223344);
    send(8'h11, 0); send(8'h44, 10); send(8'h33, 0); send(8'h22, 0);
    check("to_keep", imem_wdata, 32'h22334411);
    send(8'hA1, 0); send(8'hA2, TO - 2); send(8'hA3, TO - 1);
    send(8'hA4, 0); send(8'hA5, 0); send(8'hA6, 0);
    idle(TO + 2);

    // overflow: 4 writes then the fifth word overflows
    do_reset();
    for (int k = 0; k < 5; k++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      send_word(w);
    end
    check("ovf", {31'd0, overflow}, 32'd1);
    send_word(32'h01020304);

    // reset mid-word
    do_reset();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    do_reset();
    send_word(32'hCAFE_0001);
    check("rst_mw_a", {{(32-AW){1'b0}}, imem_addr}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit v, b, r;
      logic [7:0] d;
      r = ($urandom_range(0, 119) == 0);
      b = ($urandom_range(0, 39) == 0);
      v = (i % 200 < 150) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 24) == 0);
      d = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      step(v, d, b, r);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
